// File: rtl/mem_loader_pkg.sv
// Shared constants for the mem_loader host protocol.
// Holds the command/response byte values and the loader state encoding so that
// host-side tools and any future command decoders agree on identical values.
package mem_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h2E;
  localparam logic [7:0] RSP_NAK   = 8'h3F;

  typedef enum logic [2:0] {
    StIdle,
    StAddrHi,
    StAddrLo,
    StLen,
    StWdata,
    StRdata,
    StRsend,
    StResp
  } state_t;

  // LEN byte of 0 encodes a full 256-byte burst.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/mem_loader_idle_timer.sv
// Inter-byte idle timer for mem_loader.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clear      : restart the count (takes priority over tick)
//   tick       : one idle cycle has elapsed
//   expired    : high in the cycle whose tick completes Timeout idle cycles
// Timeout = 0 disables the timer entirely.
module mem_loader_idle_timer #(
  parameter int unsigned Timeout = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] Last = CntW'((Timeout == 0) ? 0 : Timeout - 1);
  localparam logic Enabled = (Timeout != 0);

  logic [CntW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && Enabled) begin
      count <= (count == Last) ? '0 : count + 1'b1;
    end
  end

  assign expired = Enabled && tick && !clear && (count == Last);

endmodule

// File: rtl/mem_loader.sv
// Host-facing memory loader.
// Decodes framed commands from a UART byte stream (CMD, ADDR_HI, ADDR_LO, LEN,
// then data for writes) and drives a byte-wide memory port. Read data and
// ACK/NAK bytes go back to the UART transmitter over a valid/ready handshake.
// Ports:
//   clk, reset         : clock and asynchronous active-high reset
//   rx_valid, rx_byte  : one-cycle received-byte strobe and data
//   tx_valid, tx_byte  : outgoing byte, held until tx_ready
//   tx_ready           : transmitter accepts tx_byte
//   mem_read/mem_write : registered one-cycle memory strobes
//   mem_addr           : memory address
//   mem_write_byte     : memory write data
//   mem_read_byte      : combinational memory read data
//   busy               : loader is not idle
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_write_byte,
  input  logic [7:0]  mem_read_byte,
  output logic        busy
);

  state_t      state;
  logic        is_read;
  logic [15:0] addr;
  logic [8:0]  remaining;
  logic        timed;
  logic        timed_out;

  // Only states that are waiting on the host can time out.
  assign timed = (state == StAddrHi) || (state == StAddrLo) ||
                 (state == StLen)    || (state == StWdata);

  // Every entry into a timed state happens on rx_valid or from idle, so
  // clearing on rx_valid and outside timed states restarts it on entry.
  mem_loader_idle_timer #(
    .Timeout (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_valid || !timed),
    .tick    (timed && !rx_valid),
    .expired (timed_out)
  );

  assign busy = (state != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= StIdle;
      is_read        <= 1'b0;
      addr           <= 16'd0;
      remaining      <= 9'd0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= 16'd0;
      mem_write_byte <= 8'd0;
      tx_valid       <= 1'b0;
      tx_byte        <= 8'd0;
    end else begin
      // Memory strobes are single-cycle pulses by default.
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if (timed_out) begin
        state <= StIdle;
      end else begin
        case (state)
          StIdle: begin
            if (rx_valid) begin
              if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
                is_read <= (rx_byte == CMD_READ);
                state   <= StAddrHi;
              end else begin
                tx_byte  <= RSP_NAK;
                tx_valid <= 1'b1;
                state    <= StResp;
              end
            end
          end
          StAddrHi: begin
            if (rx_valid) begin
              addr[15:8] <= rx_byte;
              state      <= StAddrLo;
            end
          end
          StAddrLo: begin
            if (rx_valid) begin
              addr[7:0] <= rx_byte;
              state     <= StLen;
            end
          end
          StLen: begin
            if (rx_valid) begin
              remaining <= len_to_count(rx_byte);
              if (is_read) begin
                mem_read <= 1'b1;
                mem_addr <= addr;
                state    <= StRdata;
              end else begin
                state <= StWdata;
              end
            end
          end
          StWdata: begin
            if (rx_valid) begin
              mem_write      <= 1'b1;
              mem_addr       <= addr;
              mem_write_byte <= rx_byte;
              addr           <= addr + 16'd1;
              remaining      <= remaining - 9'd1;
              if (remaining == 9'd1) begin
                tx_byte  <= RSP_ACK;
                tx_valid <= 1'b1;
                state    <= StResp;
              end
            end
          end
          StRdata: begin
            // mem_read is high in this cycle, so read data is valid now.
            tx_byte  <= mem_read_byte;
            tx_valid <= 1'b1;
            state    <= StRsend;
          end
          StRsend: begin
            if (tx_ready) begin
              tx_valid  <= 1'b0;
              addr      <= addr + 16'd1;
              remaining <= remaining - 9'd1;
              if (remaining == 9'd1) begin
                state <= StIdle;
              end else begin
                mem_read <= 1'b1;
                mem_addr <= addr + 16'd1;
                state    <= StRdata;
              end
            end
          end
          StResp: begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              state    <= StIdle;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table-driven frames, hand-written corner
// sequences (timeout, reset mid-read, discarded rx during read) and random
// frames, all checked against a byte-array memory model and expected queues.
module tb_mem_loader;

  localparam int unsigned To = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready = 1'b0;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [7:0]  mem_write_byte;
  logic [7:0]  mem_read_byte;
  logic        busy;

  mem_loader #(
    .TIMEOUT (To)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_valid       (rx_valid),
    .rx_byte        (rx_byte),
    .tx_valid       (tx_valid),
    .tx_byte        (tx_byte),
    .tx_ready       (tx_ready),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_write_byte (mem_write_byte),
    .mem_read_byte  (mem_read_byte),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Attached memory and the reference model of its contents.
  logic [7:0] envmem    [0:65535];
  logic [7:0] model_mem [0:65535];
  assign mem_read_byte = envmem[mem_addr];

  int checks = 0;
  int errors = 0;

  // Observed activity.
  logic [7:0]  txq[$];
  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int          wcyc[$];
  int          rxcyc[$];
  int          rd_cnt = 0;
  int          both_viol = 0;
  int          stab_viol = 0;
  int          cyc = 0;
  bit          prev_stalled = 0;
  logic [7:0]  prev_byte = 8'd0;

  // Expected activity.
  logic [7:0]  etx[$];
  logic [15:0] ewa[$];
  logic [7:0]  ewd[$];
  int          erd = 0;
  bit          chk_timing = 0;

  int stall = 0;
  int wait_cnt = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  len;
    int          gap;
    int          stl;
    int          ntx;
    int          nwr;
    int          nrd;
    int          first;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor samples just before each rising edge, where everything is settled.
  initial forever begin
    @(negedge clk);
    #4;
    if (reset) begin
      prev_stalled = 0;
    end else begin
      if (rx_valid) rxcyc.push_back(cyc);
      if (mem_write) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_write_byte);
        wcyc.push_back(cyc);
        envmem[mem_addr] = mem_write_byte;
      end
      if (mem_read) rd_cnt++;
      if (mem_read && mem_write) both_viol++;
      if (prev_stalled && (!tx_valid || tx_byte !== prev_byte)) stab_viol++;
      if (tx_valid && tx_ready) txq.push_back(tx_byte);
      prev_stalled = tx_valid && !tx_ready;
      prev_byte = tx_byte;
    end
    cyc++;
  end

  // Transmitter: hold tx_ready low for 'stall' cycles of each offered byte.
  initial forever begin
    @(negedge clk);
    if (tx_valid && !reset) begin
      if (wait_cnt >= stall) tx_ready = 1'b1;
      else begin
        tx_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      tx_ready = 1'b0;
      wait_cnt = 0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic clear_mon();
    txq.delete(); wa.delete(); wd.delete(); wcyc.delete(); rxcyc.delete();
    etx.delete(); ewa.delete(); ewd.delete();
    rd_cnt = 0; erd = 0; chk_timing = 0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " idle"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_results(input string tag);
    check({tag, " tx count"}, txq.size(), etx.size());
    for (int i = 0; i < txq.size() && i < etx.size(); i++)
      check($sformatf("%s tx[%0d]", tag, i), txq[i], etx[i]);
    check({tag, " wr count"}, wa.size(), ewa.size());
    for (int i = 0; i < wa.size() && i < ewa.size(); i++) begin
      check($sformatf("%s wr addr[%0d]", tag, i), wa[i], ewa[i]);
      check($sformatf("%s wr data[%0d]", tag, i), wd[i], ewd[i]);
    end
    check({tag, " rd pulses"}, rd_cnt, erd);
    if (chk_timing) begin
      for (int i = 0; i < wcyc.size() && i + 4 < rxcyc.size(); i++)
        check($sformatf("%s wr lag[%0d]", tag, i), wcyc[i] - rxcyc[i + 4], 32'd1);
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [7:0] len,
                           input int gap, input int stl, input bit rnd, input int ntx,
                           input int nwr, input int nrd, input int first, input string tag);
    int n;
    logic [7:0] pl[$];
    logic [15:0] a;
    logic [7:0] d;
    n = (len == 8'd0) ? 256 : int'(len);
    clear_mon();
    stall = stl;
    if (cmd == 8'h57) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 16'(i);
        d = rnd ? 8'($urandom) : 8'(8'hAA + 8'h11 * i);
        pl.push_back(d);
        ewa.push_back(a);
        ewd.push_back(d);
        model_mem[a] = d;
      end
      etx.push_back(8'h2E);
      chk_timing = 1;
    end else if (cmd == 8'h52) begin
      for (int i = 0; i < n; i++) etx.push_back(model_mem[addr + 16'(i)]);
      erd = n;
    end else begin
      etx.push_back(8'h3F);
    end
    send_byte(cmd, gap);
    if (cmd == 8'h57 || cmd == 8'h52) begin
      send_byte(addr[15:8], gap);
      send_byte(addr[7:0], gap);
      send_byte(len, gap);
      foreach (pl[i]) send_byte(pl[i], gap);
    end
    wait_idle(tag);
    compare_results(tag);
    if (ntx >= 0) begin
      check({tag, " table tx n"}, txq.size(), ntx);
      check({tag, " table wr n"}, wa.size(), nwr);
      check({tag, " table rd n"}, rd_cnt, nrd);
    end
    if (first >= 0 && txq.size() > 0) check({tag, " first tx"}, txq[0], first);
  endtask

  initial begin
    int t;
    int inj;
    int r;
    logic [7:0] c;

    for (int i = 0; i < 65536; i++) begin
      envmem[i] = 8'(i) ^ 8'h5A;
      model_mem[i] = 8'(i) ^ 8'h5A;
    end

    vecs[0] = '{8'h57, 16'h1234, 8'h03, 0, 0, 1, 3,   0, 'h2E};
    vecs[1] = '{8'h52, 16'h1234, 8'h03, 0, 5, 3, 0,   3, 'hAA};
    vecs[2] = '{8'h41, 16'h0000, 8'h00, 0, 0, 1, 0,   0, 'h3F};
    vecs[3] = '{8'h57, 16'hFFFF, 8'h00, 0, 0, 1, 256, 0, 'h2E};
    vecs[4] = '{8'h52, 16'hFFFE, 8'h04, 1, 2, 4, 0,   4, 'hA4};
    vecs[5] = '{8'h52, 16'h0000, 8'h02, 0, 0, 2, 0,   2, 'hBB};
    vecs[6] = '{8'h00, 16'h0000, 8'h00, 2, 1, 1, 0,   0, 'h3F};
    vecs[7] = '{8'h57, 16'h0010, 8'h01, 3, 1, 1, 1,   0, 'h2E};

    // Reset state.
    @(negedge clk);
    check("rst tx_valid", 32'(tx_valid), 0);
    check("rst tx_byte", 32'(tx_byte), 0);
    check("rst mem_read", 32'(mem_read), 0);
    check("rst mem_write", 32'(mem_write), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst mem_write_byte", 32'(mem_write_byte), 0);
    check("rst busy", 32'(busy), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i])
      run_frame(vecs[i].cmd, vecs[i].addr, vecs[i].len, vecs[i].gap, vecs[i].stl, 1'b0,
                vecs[i].ntx, vecs[i].nwr, vecs[i].nrd, vecs[i].first, $sformatf("vec%0d", i));

    // Timeout: frame abandoned after exactly To silent cycles, nothing sent.
    clear_mon();
    stall = 0;
    send_byte(8'h57, 0);
    send_byte(8'h12, 0);
    repeat (To - 1) @(negedge clk);
    check("timeout still busy", 32'(busy), 1);
    @(negedge clk);
    check("timeout idle", 32'(busy), 0);
    repeat (2) @(negedge clk);
    compare_results("timeout");
    run_frame(8'h52, 16'h0000, 8'h01, 0, 0, 1'b0, 1, 0, 1, 'hBB, "post-timeout");

    // Reset while a read byte is stalled in the transmit slot.
    clear_mon();
    stall = 50;
    send_byte(8'h52, 0);
    send_byte(8'h00, 0);
    send_byte(8'h20, 0);
    send_byte(8'h04, 0);
    t = 0;
    while (!tx_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rstmid tx_valid before", 32'(tx_valid), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstmid tx_valid", 32'(tx_valid), 0);
    check("rstmid mem_read", 32'(mem_read), 0);
    check("rstmid mem_write", 32'(mem_write), 0);
    check("rstmid busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    stall = 0;
    repeat (2) @(negedge clk);
    check("rstmid nothing sent", txq.size(), 0);
    run_frame(8'h57, 16'h0020, 8'h02, 0, 0, 1'b0, 1, 2, 0, 'h2E, "post-reset");

    // rx bytes while a read byte is stalled must be ignored.
    clear_mon();
    stall = 4;
    for (int i = 0; i < 3; i++) etx.push_back(model_mem[16'h1234 + 16'(i)]);
    erd = 3;
    send_byte(8'h52, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h03, 0);
    inj = 0;
    t = 0;
    while (busy && t < 500) begin
      @(negedge clk);
      #1;
      if (tx_valid && !tx_ready && inj < 6) begin
        rx_valid = 1'b1;
        rx_byte = 8'h57;
        inj++;
        @(negedge clk);
        rx_valid = 1'b0;
      end
      t++;
    end
    check("discard injected", 32'(inj > 0), 1);
    wait_idle("discard");
    compare_results("discard");

    // Random frames against the model.
    for (int k = 0; k < 25; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) c = 8'h57;
      else if (r < 8) c = 8'h52;
      else begin
        c = 8'($urandom);
        if (c == 8'h57 || c == 8'h52) c = 8'h00;
      end
      run_frame(c, 16'($urandom), 8'($urandom_range(0, 10)), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'b1, -1, -1, -1, -1, $sformatf("rnd%0d", k));
    end

    check("read/write overlap", both_viol, 0);
    check("tx stable while stalled", stab_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
